seq_booth_multiplier: RTL and testbench
=======================================

Name: seq_booth_multiplier

Overview:
Sequential signed radix-2 Booth multiplier that performs one add, subtract or skip step per clock. It sits directly upstream of the ripple_adder stage. It instantiates ripple_adder as its accumulate datapath, driving the adder operands and carry-in every cycle and registering the sum it returns. It is the low-area, multi-cycle alternative to the combinational array multipliers in the same library.

Parameters:
N, 32, operand width in bits; both operands are two's complement. Legal range is N >= 4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request to begin a multiply; sampled on a rising clk edge
a  input  N  multiplicand, signed; sampled when start is accepted
b  input  N  multiplier, signed; sampled when start is accepted
busy  output  1  high while an iteration sequence is in progress
done  output  1  one-cycle pulse; product is valid from this cycle onward
product  output  2N  signed result a*b; held until the next accepted start completes

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst); no asynchronous reset anywhere.
- Reset values: busy=0, done=0, product=0, state=IDLE, counter=0, internal registers=0.
- Reset wins over everything, including mid-operation: on the next edge with rst=1 the state goes to IDLE, any in-flight result is discarded and product is cleared to 0.
- State machine:
  - IDLE: start=1 -> LOAD. Otherwise stay in IDLE.
  - LOAD (one cycle): M <= sign-extend(a) to N+1 bits; A <= 0 (N+1 bits); Q <= b; q_1 <= 0; cnt <= 0. Always -> RUN.
  - RUN: on each edge, select the operation from {Q[0], q_1}:
    - 01: A <= A + M.
    - 10: A <= A - M, computed as A + ~M with adder cin=1.
    - 00 or 11: A unchanged; adder output is ignored.
    - Then arithmetic right shift {A, Q, q_1} by 1 bit, A[N] replicated into the top.
    - cnt <= cnt + 1.
    - When cnt == N-1 on this edge: go to FIN.
  - FIN (one cycle): product <= {A[N-1:0], Q}; done <= 1; busy <= 0. Then -> IDLE, unless start=1, in which case -> LOAD (back-to-back accept).
- Accumulator width:
  - The accumulator is N+1 bits so that a = -2^(N-1) never overflows.
  - The ripple_adder instance is width N+1.
  - Its OF and cout outputs are unused and must never be asserted in correct operation; the bench checks OF stays 0.
- Timing and latency:
  - busy = 1 in LOAD and RUN, 0 in IDLE and FIN.
  - If start is sampled at edge k, done is high during the cycle after edge k+N+1. Total latency is N+2 edges.
  - done is high for exactly one cycle.
- Start handling:
  - start is ignored while busy=1; operands a and b are not re-sampled.
  - start held high continuously produces back-to-back multiplies, each N+2 cycles.
- product changes only in FIN or on reset; it is stable at all other times.
- Counter width is clog2(N)+1 bits. cnt is not exposed.

Test Plan:
1. N=8; rst for 2 cycles, then release -> busy=0, done=0, product=0; with no start, all outputs hold.
2. N=8; a=3, b=5, 1-cycle start at edge k -> done pulse in the cycle after edge k+9, product=15; busy high exactly 9 cycles.
3. N=8 sign cases: a=-7,b=6 -> -42 (16'hFFD6); a=127,b=-128 -> -16256 (16'hC080); a=-128,b=-128 -> 16384 (16'h4000); a=0,b=-1 -> 0. Adder OF stays 0 throughout.
4. N=8; a=3,b=5 start, then start pulse with a=9,b=9 at edge k+4 -> second start ignored; product=15; no second done.
5. N=8; a=-5,b=7 start, rst asserted at edge k+5 -> next cycle busy=0, product=0, no done; new start a=2,b=2 -> product=4.
6. N=32; start held high, operand pairs (12345,-6789) then (-2^31,-2^31) -> two done pulses 34 cycles apart; products -83810205 and 2^62.

Source files
------------

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: signed radix-2 Booth multiplier, one add/sub/skip step per clock
module ripple_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         of_o
);
  logic [W:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[W];
  assign of_o   = c[W] ^ c[W-1];
endmodule

module seq_booth_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;
  logic [1:0]     state_q, state_d;
  logic [N:0]     m_q, m_d, acc_q, acc_d, sum, acc_n;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d, done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           add_en, sub, cout_unused, of_unused;
  // Idle and skip steps feed zero to the adder so it never sees an overflowing operand pair
  assign sub    = q_q[0] & ~q1_q;
  assign add_en = (state_q == RUN) && (q_q[0] ^ q1_q);
  ripple_adder #(.W(N + 1)) u_add (
    .a_i   (acc_q),
    .b_i   (add_en ? (sub ? ~m_q : m_q) : '0),
    .cin_i (add_en & sub),
    .sum_o (sum),
    .cout_o(cout_unused),
    .of_o  (of_unused)
  );
  assign acc_n   = add_en ? sum : acc_q;
  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;
  // Next-state: load operands, then N add/sub + arithmetic-shift steps, then publish
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;
    unique case (state_q)
      IDLE, FIN: state_d = start ? LOAD : IDLE;
      LOAD: begin
        m_d     = {a[N-1], a};
        acc_d   = '0;
        q_d     = b;
        q1_d    = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      default: begin
        acc_d = {acc_n[N], acc_n[N:1]};
        q_d   = {acc_n[0], q_q[N-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d   = FIN;
          done_d    = 1'b1;
          product_d = {acc_n, q_q[N-1:1]};
        end
      end
    endcase
  end
  // State registers with synchronous reset that discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed and random checks of the Booth multiplier at N=8 and N=32
module tb_seq_booth_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start32 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy8, done8, busy32, done32;
  logic [15:0] product8;
  logic [63:0] product32;
  int vectors = 0, miscompares = 0, of_hits = 0;

  seq_booth_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );
  seq_booth_multiplier #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(product32)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dut8.of_unused || dut32.of_unused) of_hits++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint ref_mul8(input logic [7:0] x, input logic [7:0] y);
    return longint'($signed(x)) * longint'($signed(y));
  endfunction

  task automatic mul8(input logic [7:0] x, input logic [7:0] y);
    longint e;
    int lat, bc;
    e = ref_mul8(x, y);
    @(negedge clk); a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0; lat = 0; bc = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      @(negedge clk); lat++;
    end
    check("lat8", 64'(lat), 64'd9);
    check("busy_cycles8", 64'(bc), 64'd9);
    check("prod8", 64'(product8), 64'(e[15:0]));
    check("busy_at_done8", 64'(busy8), 64'd0);
    @(negedge clk);
    check("done_width8", 64'(done8), 64'd0);
    check("prod_hold8", 64'(product8), 64'(e[15:0]));
  endtask

  task automatic count_dones8(input int cycles, input string tag);
    int d;
    d = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done8) d++;
    end
    check(tag, 64'(d), 64'd0);
  endtask

  initial begin
    int lat, gap, bc;
    longint e;
    // reset and idle hold
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(product8), 64'd0);
    check("rst_prod32", product32, 64'd0);
    repeat (5) @(negedge clk);
    check("idle_busy8", 64'(busy8), 64'd0);
    check("idle_done8", 64'(done8), 64'd0);
    check("idle_prod8", 64'(product8), 64'd0);
    // basic and sign cases
    mul8(8'd3, 8'd5);
    mul8(-8'sd7, 8'd6);
    mul8(8'd127, 8'h80);
    mul8(8'h80, 8'h80);
    mul8(8'd0, 8'hFF);
    mul8(8'hFF, 8'hFF);
    mul8(8'h80, 8'd1);
    for (int i = 0; i < 10; i++) mul8(8'($urandom), 8'($urandom));
    // start while busy is ignored
    @(negedge clk); a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("ignore_lat8", 64'(lat), 64'd5);
    check("ignore_prod8", 64'(product8), 64'd15);
    count_dones8(20, "ignore_no_second_done");
    check("ignore_prod_hold", 64'(product8), 64'd15);
    // reset mid-operation
    @(negedge clk); a8 = -8'sd5; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_prod", 64'(product8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    count_dones8(15, "midrst_no_done");
    mul8(8'd2, 8'd2);
    // N=32 back-to-back with start held high
    @(negedge clk); a32 = 32'd12345; b32 = -32'sd6789; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk); lat = 0;
    repeat (3) @(negedge clk);
    a32 = 32'h8000_0000; b32 = 32'h8000_0000; lat = 3;
    while (!done32 && lat < 100) begin @(negedge clk); lat++; end
    check("lat32", 64'(lat), 64'd33);
    e = -64'sd83810205;
    check("prod32_a", product32, 64'(e));
    @(negedge clk); gap = 1; bc = 0;
    while (!done32 && gap < 100) begin
      if (busy32) bc++;
      @(negedge clk); gap++;
    end
    start32 = 1'b0;
    check("gap32", 64'(gap), 64'd34);
    check("busy_cycles32", 64'(bc), 64'd33);
    check("prod32_b", product32, 64'h4000_0000_0000_0000);
    repeat (40) @(negedge clk);
    check("idle_after_b2b32", 64'(busy32), 64'd0);
    check("prod32_hold", product32, 64'h4000_0000_0000_0000);
    check("adder_of", 64'(of_hits), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
